dbus_sram_responder: RTL and testbench
======================================

// Module: dbus_sram_responder
// PURPOSE
//  Target-side model of the core's data bus: accepts dbus_req_t from the memory stage, answers with
//  dbus_resp_t after a programmable latency. Backed by an internal 64-bit-wide synchronous SRAM.
//  Used as the dbus endpoint in standalone core benches and as the on-chip scratchpad behind the bus mux.
// PARAMETERS
//  DEPTH    1024  number of 64-bit words (power of two, >=2); AW = $clog2(DEPTH)
//  BASE     64'h8000_0000  byte address of word 0
//  LATENCY  2     wait cycles between request capture and response (0..15)
// PORTS
//  clk        input   1    clock
//  reset      input   1    synchronous, active-high reset
//  dreq       input   dbus_req_t   {valid, addr[63:0], size[2:0], strobe[7:0], data[63:0]} from core
//  dresp      output  dbus_resp_t  {addr_ok, data_ok, data[63:0]} to core
//  err        output  1    one-cycle pulse with data_ok when the request address was out of range
//  txn_cnt    output  32   completed transactions since reset, wraps at 2^32
// BEHAVIOUR
//  - Reset: state=IDLE, addr_ok=0, data_ok=0, data=0, err=0, txn_cnt=0, counter=0. SRAM contents kept.
//  - States: IDLE, WAIT, RESP. All dresp fields and err are registered.
//  - IDLE: if dreq.valid, capture addr/strobe/data, write flag (strobe!=0), in_range; go RESP when
//    LATENCY==0, else WAIT with cnt=LATENCY-1. Otherwise stay.
//  - WAIT: if dreq.valid==0 -> abort to IDLE, no write, no response. Else cnt==0 -> RESP, else cnt--.
//  - RESP (1 cycle): addr_ok=data_ok=1; next state IDLE; txn_cnt++.
//    load: data = mem[idx] (value before any write this cycle); store: data=0, commit write.
//  - Response timing: valid first seen in IDLE at cycle T -> data_ok high in cycle T+1+LATENCY only.
//  - Index: idx = (addr-BASE)[AW+2:3]; in_range = BASE <= addr < BASE+8*DEPTH.
//  - Store: byte lane i of mem[idx] gets data[8i+7:8i] iff strobe[i]; core pre-aligns data/strobe,
//    size is informational only. Loads return the full aligned word; core extracts/extends.
//  - Out of range: no SRAM access, data=0, err=1 with data_ok; still counted in txn_cnt.
//  - Captured request is used; changes to dreq addr/data during WAIT are ignored (only valid checked).
//  - After RESP the block is in IDLE; a valid still high in that cycle is a NEW transaction
//    (core holds same request only while stalled waiting on data_ok, so no duplicate occurs).
//  - Outputs outside RESP: addr_ok=data_ok=err=0, data=0.
//  - Reset mid-WAIT/RESP: transaction dropped, no write committed, no data_ok, txn_cnt=0.
//  - txn_cnt increments on the RESP cycle edge; 32'hFFFF_FFFF -> 0.
// TESTING
//  1 LATENCY=2: store addr=BASE+8 data=64'h1122_3344_5566_7788 strobe=FF at T -> data_ok only at T+3,
//    then load BASE+8 -> data=64'h1122_3344_5566_7788, txn_cnt=2.
//  2 Byte strobe: word=0, store strobe=8'h0F data=64'hAAAA_AAAA_BBBB_BBBB -> load reads 64'h0000_0000_BBBB_BBBB.
//  3 Out of range: load addr=BASE+8*DEPTH -> data_ok with err=1, data=0; SRAM unchanged.
//  4 Abort: store issued, valid dropped during WAIT -> no data_ok, later load of that word shows old value.
//  5 Back-to-back: valid held high across two requests -> two data_ok pulses spaced LATENCY+2 cycles.
//  6 Reset asserted in WAIT of a store -> all outputs 0 next cycle, txn_cnt=0, word unchanged; LATENCY=0
//    run: data_ok at T+1.

Source files
------------

// File: rtl/dbus_sram_responder.sv
// Data-bus target backed by a byte-writable 64-bit synchronous SRAM.
// Each request is answered with a single registered response after a fixed number of wait cycles.
package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int          DEPTH   = 1024,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  dbus_req_t   dreq,
  output dbus_resp_t  dresp,
  output logic        err,
  output logic [31:0] txn_cnt
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [63:0] LIMIT    = BASE + 64'(DEPTH) * 64'd8;
  localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [63:0]   req_off;
  logic [AW-1:0] req_idx;
  logic          req_in_range;

  assign req_off      = dreq.addr - BASE;
  assign req_idx      = req_off[AW+2:3];
  assign req_in_range = (dreq.addr >= BASE) && (dreq.addr < LIMIT);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          in_range_q, in_range_d;
  logic          store_q, store_d;
  logic [7:0]    strobe_q, strobe_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          addr_ok_q, addr_ok_d;
  logic          data_ok_q, data_ok_d;
  logic          err_q, err_d;
  logic [31:0]   txn_cnt_q, txn_cnt_d;

  logic          enter_resp;
  logic          rd_en;
  logic [AW-1:0] rd_idx;
  logic          wr_en;
  logic [63:0]   rd_word;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    in_range_d = in_range_q;
    store_d    = store_q;
    strobe_d   = strobe_q;
    wdata_d    = wdata_q;
    txn_cnt_d  = txn_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (dreq.valid) begin
          idx_d      = req_idx;
          in_range_d = req_in_range;
          store_d    = |dreq.strobe;
          strobe_d   = dreq.strobe;
          wdata_d    = dreq.data;
          if (LATENCY == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        // Dropping valid while waiting cancels the request outright.
        if (!dreq.valid) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d   = S_IDLE;
        txn_cnt_d = txn_cnt_q + 32'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decided on the edge that enters RESP.
    enter_resp = (state_d == S_RESP);
    addr_ok_d  = enter_resp;
    data_ok_d  = enter_resp;
    err_d      = enter_resp && !in_range_d;
    rd_en      = enter_resp && in_range_d && !store_d;
    rd_idx     = idx_d;
    wr_en      = (state_q == S_RESP) && store_q && in_range_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      in_range_q <= 1'b0;
      store_q    <= 1'b0;
      strobe_q   <= 8'd0;
      wdata_q    <= 64'd0;
      addr_ok_q  <= 1'b0;
      data_ok_q  <= 1'b0;
      err_q      <= 1'b0;
      txn_cnt_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      in_range_q <= in_range_d;
      store_q    <= store_d;
      strobe_q   <= strobe_d;
      wdata_q    <= wdata_d;
      addr_ok_q  <= addr_ok_d;
      data_ok_q  <= data_ok_d;
      err_q      <= err_d;
      txn_cnt_q  <= txn_cnt_d;
    end
  end

  // One narrow RAM per byte lane keeps byte-enable writes simple.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] lane_rd_q;

    always_ff @(posedge clk) begin
      if (!reset && wr_en && strobe_q[gi]) begin
        lane_mem[idx_q] <= wdata_q[8*gi +: 8];
      end
      if (reset || !rd_en) begin
        lane_rd_q <= 8'd0;
      end else begin
        lane_rd_q <= lane_mem[rd_idx];
      end
    end

    assign rd_word[8*gi +: 8] = lane_rd_q;
  end

  assign dresp   = '{addr_ok: addr_ok_q, data_ok: data_ok_q, data: rd_word};
  assign err     = err_q;
  assign txn_cnt = txn_cnt_q;

  // Access size is advisory only; upper offset bits matter only through the range check.
  logic unused_bits;
  assign unused_bits = ^{dreq.size, req_off};
endmodule

// File: tb/tb_dbus_sram_responder.sv
// Randomized bench for dbus_sram_responder: a LATENCY=2 instance and a LATENCY=0 instance,
// both compared against an array-based memory model and a transaction counter.
module tb_dbus_sram_responder;
  import dbus_pkg::*;

  localparam int          DEPTH = 64;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          LAT2  = 2;

  logic        clk = 1'b0;
  logic        reset;
  dbus_req_t   dreq2, dreq0;
  dbus_resp_t  dresp2, dresp0;
  logic        err2, err0;
  logic [31:0] cnt2, cnt0;

  always #5 clk = ~clk;

  dbus_sram_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT2)) dut (
    .clk(clk), .reset(reset), .dreq(dreq2), .dresp(dresp2), .err(err2), .txn_cnt(cnt2)
  );

  dbus_sram_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .dreq(dreq0), .dresp(dresp0), .err(err0), .txn_cnt(cnt0)
  );

  int total = 0;
  int bad = 0;

  logic [63:0] model2 [DEPTH];
  logic [63:0] model0 [DEPTH];
  int unsigned mcnt2 = 0;
  int unsigned mcnt0 = 0;

  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(DEPTH * 8));
  endfunction

  function automatic int widx(input logic [63:0] a);
    return int'((a - BASE) / 64'd8);
  endfunction

  // Reference behaviour: loads return the stored word, stores merge enabled bytes,
  // out-of-range requests touch nothing but still complete.
  task automatic model_apply(input bit which, input logic [63:0] a, input logic [7:0] s,
                             input logic [63:0] d, output logic [63:0] exp_data, output logic exp_err);
    int i;
    exp_err  = !in_rng(a);
    exp_data = 64'd0;
    if (which) mcnt0++; else mcnt2++;
    if (!exp_err) begin
      i = widx(a);
      if (s == 8'd0) begin
        exp_data = which ? model0[i] : model2[i];
      end else begin
        for (int b = 0; b < 8; b++) begin
          if (s[b]) begin
            if (which) model0[i][8*b +: 8] = d[8*b +: 8];
            else       model2[i][8*b +: 8] = d[8*b +: 8];
          end
        end
      end
    end
  endtask

  task automatic set_req(input bit which, input logic v, input logic [63:0] a,
                         input logic [7:0] s, input logic [63:0] d);
    dbus_req_t r;
    r.valid  = v;
    r.addr   = a;
    r.size   = 3'($urandom_range(0, 3));
    r.strobe = s;
    r.data   = d;
    if (which) dreq0 = r; else dreq2 = r;
  endtask

  // Issues one request at a negedge, scrambles the bus while waiting, returns the number of
  // cycles until data_ok (-1 on timeout) and finishes with one idle cycle.
  task automatic do_txn(input bit which, input logic [63:0] a, input logic [7:0] s,
                        input logic [63:0] d, output int n, output logic [63:0] rdata,
                        output logic rerr, output logic aok);
    bit got;
    got   = 1'b0;
    n     = 0;
    rdata = 64'd0;
    rerr  = 1'b0;
    aok   = 1'b0;
    set_req(which, 1'b1, a, s, d);
    while (!got && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if ((which ? dresp0.data_ok : dresp2.data_ok) === 1'b1) begin
        got   = 1'b1;
        rdata = which ? dresp0.data : dresp2.data;
        rerr  = which ? err0 : err2;
        aok   = which ? dresp0.addr_ok : dresp2.addr_ok;
      end else begin
        set_req(which, 1'b1, {$urandom, $urandom}, 8'($urandom), {$urandom, $urandom});
      end
    end
    if (!got) n = -1;
    set_req(which, 1'b0, 64'd0, 8'd0, 64'd0);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [63:0] rand_addr();
    int unsigned k;
    k = $urandom_range(0, 99);
    if (k < 8)  return BASE + 64'(DEPTH * 8) + 64'($urandom_range(0, 255));
    if (k < 14) return BASE - 64'($urandom_range(1, 255));
    return BASE + 64'($urandom_range(0, DEPTH - 1)) * 64'd8 + 64'($urandom_range(0, 7));
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    set_req(0, 1'b0, 64'd0, 8'd0, 64'd0);
    set_req(1, 1'b0, 64'd0, 8'd0, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (dresp2.addr_ok !== 1'b0) begin bad++; $display("FAIL rst_addr_ok got=%b want=0", dresp2.addr_ok); end
    total++; if (dresp2.data_ok !== 1'b0) begin bad++; $display("FAIL rst_data_ok got=%b want=0", dresp2.data_ok); end
    total++; if (dresp2.data !== 64'd0) begin bad++; $display("FAIL rst_data got=%h want=0", dresp2.data); end
    total++; if (err2 !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err2); end
    total++; if (cnt2 !== 32'd0) begin bad++; $display("FAIL rst_txn_cnt got=%0d want=0", cnt2); end
    total++; if (dresp0.data_ok !== 1'b0 || cnt0 !== 32'd0) begin bad++; $display("FAIL rst_lat0 got=%b/%0d want=0/0", dresp0.data_ok, cnt0); end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_store_load();
    int n; logic [63:0] rd, exp; logic e, ok, ee;
    do_txn(0, BASE + 64'd8, 8'hFF, 64'h1122_3344_5566_7788, n, rd, e, ok);
    model_apply(0, BASE + 64'd8, 8'hFF, 64'h1122_3344_5566_7788, exp, ee);
    total++; if (n !== LAT2 + 1) begin bad++; $display("FAIL sl_store_latency got=%0d want=%0d", n, LAT2 + 1); end
    total++; if (ok !== 1'b1 || e !== 1'b0) begin bad++; $display("FAIL sl_store_flags got=%b%b want=10", ok, e); end
    total++; if (rd !== 64'd0) begin bad++; $display("FAIL sl_store_data got=%h want=0", rd); end
    do_txn(0, BASE + 64'd8, 8'h00, 64'd0, n, rd, e, ok);
    model_apply(0, BASE + 64'd8, 8'h00, 64'd0, exp, ee);
    total++; if (n !== LAT2 + 1) begin bad++; $display("FAIL sl_load_latency got=%0d want=%0d", n, LAT2 + 1); end
    total++; if (rd !== 64'h1122_3344_5566_7788) begin bad++; $display("FAIL sl_load_data got=%h want=%h", rd, 64'h1122_3344_5566_7788); end
    total++; if (cnt2 !== 32'd2) begin bad++; $display("FAIL sl_txn_cnt got=%0d want=2", cnt2); end
  endtask

  task automatic test_fill();
    int n; logic [63:0] rd, exp, d; logic e, ok, ee;
    for (int i = 0; i < DEPTH; i++) begin
      d = {$urandom, $urandom};
      do_txn(0, BASE + 64'(i) * 64'd8, 8'hFF, d, n, rd, e, ok);
      model_apply(0, BASE + 64'(i) * 64'd8, 8'hFF, d, exp, ee);
      total++; if (n !== LAT2 + 1 || e !== 1'b0) begin bad++; $display("FAIL fill_%0d got=%0d/%b want=%0d/0", i, n, e, LAT2 + 1); end
    end
  endtask

  task automatic test_strobe();
    int n; logic [63:0] rd, exp; logic e, ok, ee;
    logic [63:0] a;
    a = BASE + 64'd40;
    do_txn(0, a, 8'hFF, 64'd0, n, rd, e, ok);
    model_apply(0, a, 8'hFF, 64'd0, exp, ee);
    do_txn(0, a, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, n, rd, e, ok);
    model_apply(0, a, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, exp, ee);
    do_txn(0, a, 8'h00, 64'd0, n, rd, e, ok);
    model_apply(0, a, 8'h00, 64'd0, exp, ee);
    total++; if (rd !== 64'h0000_0000_BBBB_BBBB) begin bad++; $display("FAIL strobe_low got=%h want=%h", rd, 64'h0000_0000_BBBB_BBBB); end
    do_txn(0, a, 8'hA5, 64'h0102_0304_0506_0708, n, rd, e, ok);
    model_apply(0, a, 8'hA5, 64'h0102_0304_0506_0708, exp, ee);
    do_txn(0, a + 64'd3, 8'h00, 64'd0, n, rd, e, ok);
    model_apply(0, a + 64'd3, 8'h00, 64'd0, exp, ee);
    total++; if (rd !== exp) begin bad++; $display("FAIL strobe_mixed got=%h want=%h", rd, exp); end
  endtask

  task automatic test_out_of_range();
    int n; logic [63:0] rd, exp; logic e, ok, ee;
    do_txn(0, BASE + 64'(DEPTH * 8), 8'h00, 64'd0, n, rd, e, ok);
    model_apply(0, BASE + 64'(DEPTH * 8), 8'h00, 64'd0, exp, ee);
    total++; if (n !== LAT2 + 1) begin bad++; $display("FAIL oor_latency got=%0d want=%0d", n, LAT2 + 1); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL oor_err got=%b want=1", e); end
    total++; if (rd !== 64'd0) begin bad++; $display("FAIL oor_data got=%h want=0", rd); end
    total++; if (err2 !== 1'b0) begin bad++; $display("FAIL oor_err_pulse got=%b want=0", err2); end
    // A store just past the end must not alias onto word 0.
    do_txn(0, BASE + 64'(DEPTH * 8), 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, n, rd, e, ok);
    model_apply(0, BASE + 64'(DEPTH * 8), 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, exp, ee);
    do_txn(0, BASE - 64'd8, 8'h00, 64'd0, n, rd, e, ok);
    model_apply(0, BASE - 64'd8, 8'h00, 64'd0, exp, ee);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL oor_below_err got=%b want=1", e); end
    do_txn(0, BASE, 8'h00, 64'd0, n, rd, e, ok);
    model_apply(0, BASE, 8'h00, 64'd0, exp, ee);
    total++; if (rd !== exp) begin bad++; $display("FAIL oor_word0_kept got=%h want=%h", rd, exp); end
    total++; if (cnt2 !== mcnt2) begin bad++; $display("FAIL oor_txn_cnt got=%0d want=%0d", cnt2, mcnt2); end
  endtask

  task automatic test_abort();
    int n, pulses; logic [63:0] rd, exp, a; logic e, ok, ee;
    a = BASE + 64'd56;
    set_req(0, 1'b1, a, 8'hFF, 64'h5A5A_5A5A_5A5A_5A5A);
    @(posedge clk);
    @(negedge clk);
    set_req(0, 1'b0, a, 8'hFF, 64'h5A5A_5A5A_5A5A_5A5A);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (dresp2.data_ok === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL abort_no_resp got=%0d want=0", pulses); end
    total++; if (cnt2 !== mcnt2) begin bad++; $display("FAIL abort_txn_cnt got=%0d want=%0d", cnt2, mcnt2); end
    do_txn(0, a, 8'h00, 64'd0, n, rd, e, ok);
    model_apply(0, a, 8'h00, 64'd0, exp, ee);
    total++; if (rd !== exp) begin bad++; $display("FAIL abort_word_kept got=%h want=%h", rd, exp); end
  endtask

  task automatic test_back_to_back();
    int c, p1, p2, pulses; logic [63:0] d1, d2, e1, e2, a1, a2; logic ee;
    a1 = BASE + 64'd24;
    a2 = BASE + 64'd72;
    model_apply(0, a1, 8'h00, 64'd0, e1, ee);
    model_apply(0, a2, 8'h00, 64'd0, e2, ee);
    set_req(0, 1'b1, a1, 8'h00, 64'd0);
    p1 = -1; p2 = -1; pulses = 0; d1 = 64'd0; d2 = 64'd0;
    for (c = 1; c <= 16; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (dresp2.data_ok === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          p1 = c; d1 = dresp2.data;
          set_req(0, 1'b1, a2, 8'h00, 64'd0);
        end else if (pulses == 2) begin
          p2 = c; d2 = dresp2.data;
          set_req(0, 1'b0, 64'd0, 8'h00, 64'd0);
        end
      end
    end
    total++; if (pulses !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d want=2", pulses); end
    total++; if (p1 !== LAT2 + 1) begin bad++; $display("FAIL b2b_first got=%0d want=%0d", p1, LAT2 + 1); end
    total++; if (p2 - p1 !== LAT2 + 2) begin bad++; $display("FAIL b2b_spacing got=%0d want=%0d", p2 - p1, LAT2 + 2); end
    total++; if (d1 !== e1 || d2 !== e2) begin bad++; $display("FAIL b2b_data got=%h,%h want=%h,%h", d1, d2, e1, e2); end
  endtask

  task automatic test_random();
    int n, errs; logic [63:0] rd, exp, a, d; logic [7:0] s; logic e, ok, ee;
    errs = 0;
    for (int t = 0; t < 150; t++) begin
      a = rand_addr();
      s = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      d = {$urandom, $urandom};
      do_txn(0, a, s, d, n, rd, e, ok);
      model_apply(0, a, s, d, exp, ee);
      total++;
      if (n !== LAT2 + 1 || ok !== 1'b1 || e !== ee || rd !== exp) begin
        bad++;
        $display("FAIL rand_%0d addr=%h strobe=%h got lat=%0d ok=%b err=%b data=%h want lat=%0d ok=1 err=%b data=%h",
                 t, a, s, n, ok, e, rd, LAT2 + 1, ee, exp);
      end
    end
    total++; if (cnt2 !== mcnt2) begin bad++; $display("FAIL rand_txn_cnt got=%0d want=%0d", cnt2, mcnt2); end
  endtask

  task automatic test_reset_mid();
    int n; logic [63:0] rd, exp, a; logic e, ok, ee;
    a = BASE + 64'd88;
    set_req(0, 1'b1, a, 8'hFF, 64'hC0FF_EE00_C0FF_EE00);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (dresp2.data_ok !== 1'b0 || dresp2.addr_ok !== 1'b0) begin bad++; $display("FAIL rmid_flags got=%b%b want=00", dresp2.addr_ok, dresp2.data_ok); end
    total++; if (dresp2.data !== 64'd0 || err2 !== 1'b0) begin bad++; $display("FAIL rmid_data got=%h/%b want=0/0", dresp2.data, err2); end
    total++; if (cnt2 !== 32'd0) begin bad++; $display("FAIL rmid_txn_cnt got=%0d want=0", cnt2); end
    reset = 1'b0;
    mcnt2 = 0;
    mcnt0 = 0;
    set_req(0, 1'b0, 64'd0, 8'h00, 64'd0);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      total++; if (dresp2.data_ok !== 1'b0) begin bad++; $display("FAIL rmid_late_resp got=%b want=0", dresp2.data_ok); end
    end
    do_txn(0, a, 8'h00, 64'd0, n, rd, e, ok);
    model_apply(0, a, 8'h00, 64'd0, exp, ee);
    total++; if (rd !== exp) begin bad++; $display("FAIL rmid_word_kept got=%h want=%h", rd, exp); end
    total++; if (cnt2 !== mcnt2) begin bad++; $display("FAIL rmid_cnt_after got=%0d want=%0d", cnt2, mcnt2); end
  endtask

  task automatic test_latency0();
    int n; logic [63:0] rd, exp, d; logic e, ok, ee;
    for (int t = 0; t < 6; t++) begin
      d = {$urandom, $urandom};
      do_txn(1, BASE + 64'(t) * 64'd8, 8'hFF, d, n, rd, e, ok);
      model_apply(1, BASE + 64'(t) * 64'd8, 8'hFF, d, exp, ee);
      total++; if (n !== 1 || rd !== 64'd0) begin bad++; $display("FAIL lat0_store_%0d got=%0d/%h want=1/0", t, n, rd); end
    end
    for (int t = 5; t >= 0; t--) begin
      do_txn(1, BASE + 64'(t) * 64'd8 + 64'd4, 8'h00, 64'd0, n, rd, e, ok);
      model_apply(1, BASE + 64'(t) * 64'd8 + 64'd4, 8'h00, 64'd0, exp, ee);
      total++; if (n !== 1 || rd !== exp) begin bad++; $display("FAIL lat0_load_%0d got=%0d/%h want=1/%h", t, n, rd, exp); end
    end
    do_txn(1, BASE + 64'(DEPTH * 8) + 64'd16, 8'h00, 64'd0, n, rd, e, ok);
    model_apply(1, BASE + 64'(DEPTH * 8) + 64'd16, 8'h00, 64'd0, exp, ee);
    total++; if (n !== 1 || e !== 1'b1 || rd !== 64'd0) begin bad++; $display("FAIL lat0_oor got=%0d/%b/%h want=1/1/0", n, e, rd); end
    total++; if (cnt0 !== mcnt0) begin bad++; $display("FAIL lat0_txn_cnt got=%0d want=%0d", cnt0, mcnt0); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_fill();
    test_strobe();
    test_out_of_range();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_latency0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
